// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: sequencer for one output-stationary systolic array tile.
// Runs each job as clear -> feed K operand beats (with stall) -> flush skew -> drain columns -> done.
// Optional feature macro SA_CTRL_PERF_EN adds per-job cycle and stall counters (o_perf_cycles, o_perf_stalls).
module systolic_array_ctrl #(
  parameter int S_WIDTH  = 2,
  parameter int S_HEIGHT = 2,
  parameter int K_WIDTH  = 8
) (
  input  logic                                           i_clk,
  input  logic                                           i_nrst,
  input  logic                                           i_start,
  input  logic [K_WIDTH-1:0]                             i_k_len,
  input  logic                                           i_opnd_valid,
  output logic                                           o_ready,
  output logic                                           o_opnd_rd,
  output logic                                           o_feed_zero,
  output logic                                           o_reg_clear,
  output logic                                           o_pe_en,
  output logic                                           o_psum_out_en,
  output logic                                           o_ofmap_valid,
  output logic [((S_WIDTH > 1) ? $clog2(S_WIDTH) : 1)-1:0] o_drain_col,
  output logic                                           o_done
`ifdef SA_CTRL_PERF_EN
  , output logic [31:0]                                  o_perf_cycles
  , output logic [31:0]                                  o_perf_stalls
`endif
);

  localparam int COL_W      = (S_WIDTH > 1) ? $clog2(S_WIDTH) : 1;
  localparam int FLUSH_LEN  = S_WIDTH + S_HEIGHT - 2;
  localparam int FL_W       = $clog2(S_WIDTH + S_HEIGHT + 1);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(S_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FEED, ST_FLUSH, ST_DRAIN, ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [K_WIDTH-1:0] beat_q, beat_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               accept;

  assign accept = (state_q == ST_IDLE) && i_start;

  // State and counter registers; reset aborts any job in flight
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      col_q   <= col_d;
    end
  end

  // Next-state logic; K is latched at start so later i_k_len changes are harmless
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          k_d     = i_k_len;
          beat_d  = '0;
          state_d = (i_k_len == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        beat_d  = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (i_opnd_valid) begin
          if (beat_q == k_q - K_WIDTH'(1)) begin
            beat_d  = '0;
            flush_d = '0;
            col_d   = '0;
            state_d = (FLUSH_LEN == 0) ? ST_DRAIN : ST_FLUSH;
          end else begin
            beat_d = beat_q + K_WIDTH'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          flush_d = '0;
          col_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = ST_DONE;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode; only the FEED pop/enable look at i_opnd_valid
  always_comb begin
    o_ready       = (state_q == ST_IDLE);
    o_reg_clear   = (state_q == ST_CLEAR);
    o_opnd_rd     = (state_q == ST_FEED) && i_opnd_valid;
    o_pe_en       = ((state_q == ST_FEED) && i_opnd_valid) || (state_q == ST_FLUSH);
    o_feed_zero   = (state_q == ST_FLUSH);
    o_psum_out_en = (state_q == ST_DRAIN);
    o_ofmap_valid = (state_q == ST_DRAIN);
    o_drain_col   = (state_q == ST_DRAIN) ? col_q : '0;
    o_done        = (state_q == ST_DONE);
  end

`ifdef SA_CTRL_PERF_EN
  logic [31:0] run_q, run_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Count busy and stall cycles of the running job, publish both when it finishes
  always_comb begin
    run_d         = run_q;
    stall_d       = stall_q;
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (accept) begin
      run_d   = '0;
      stall_d = '0;
    end else if (state_q != ST_IDLE) begin
      run_d = (run_q == 32'hFFFF_FFFF) ? run_q : run_q + 32'd1;
      if ((state_q == ST_FEED) && !i_opnd_valid) begin
        stall_d = (stall_q == 32'hFFFF_FFFF) ? stall_q : stall_q + 32'd1;
      end
    end
    if (state_q == ST_DONE) begin
      perf_cycles_d = (run_q == 32'hFFFF_FFFF) ? run_q : run_q + 32'd1;
      perf_stalls_d = stall_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      run_q         <= '0;
      stall_q       <= '0;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      run_q         <= run_d;
      stall_q       <= stall_d;
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign o_perf_cycles = perf_cycles_q;
  assign o_perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Testbench for systolic_array_ctrl with S_WIDTH=S_HEIGHT=2, K_WIDTH=8.
// Cycle tables plus hand sequences for K=255, async reset and stalled jobs.
module tb_systolic_array_ctrl;

  logic       clk;
  logic       nrst;
  logic       start;
  logic [7:0] kLen;
  logic       opndValid;
  logic       ready, opndRd, feedZero, regClear, peEn, psumOutEn, ofmapValid, done;
  logic [0:0] drainCol;
`ifdef SA_CTRL_PERF_EN
  logic [31:0] perfCycles, perfStalls;
`endif

  int checkCount = 0;
  int passCount  = 0;

  systolic_array_ctrl #(.S_WIDTH(2), .S_HEIGHT(2), .K_WIDTH(8)) dut (
    .i_clk         (clk),
    .i_nrst        (nrst),
    .i_start       (start),
    .i_k_len       (kLen),
    .i_opnd_valid  (opndValid),
    .o_ready       (ready),
    .o_opnd_rd     (opndRd),
    .o_feed_zero   (feedZero),
    .o_reg_clear   (regClear),
    .o_pe_en       (peEn),
    .o_psum_out_en (psumOutEn),
    .o_ofmap_valid (ofmapValid),
    .o_drain_col   (drainCol),
    .o_done        (done)
`ifdef SA_CTRL_PERF_EN
    , .o_perf_cycles (perfCycles)
    , .o_perf_stalls (perfStalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: {ready, rd, feedZero, clear, peEn, psumOutEn, ofmapValid, drainCol, done}
  logic [8:0] actOut;
  assign actOut = {ready, opndRd, feedZero, regClear, peEn, psumOutEn, ofmapValid, drainCol, done};

  localparam logic [8:0] O_IDLE  = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_CLEAR = 9'b0_0_0_1_0_0_0_0_0;
  localparam logic [8:0] O_FEEDV = 9'b0_1_0_0_1_0_0_0_0;
  localparam logic [8:0] O_FEEDS = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_FLUSH = 9'b0_0_1_0_1_0_0_0_0;
  localparam logic [8:0] O_DR0   = 9'b0_0_0_0_0_1_1_0_0;
  localparam logic [8:0] O_DR1   = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] O_DONE  = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct {
    logic       start;
    logic [7:0] k;
    logic       valid;
    logic [8:0] expOut;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic s, input logic [7:0] k, input logic v,
                        input logic [8:0] e, input string n);
    vec_t t;
    t.start = s; t.k = k; t.valid = v; t.expOut = e; t.name = n;
    vecs.push_back(t);
  endtask

  task automatic checkVal(input string name, input longint act, input longint expv);
    checkCount++;
    if (act == expv) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic checkOutput(input string name, input logic [8:0] expv);
    checkVal(name, longint'(actOut), longint'(expv));
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the falling edge for sampling
  task automatic applyStimulus(input logic s, input logic [7:0] k, input logic v);
    @(posedge clk);
    #1;
    start = s; kLen = k; opndValid = v;
    @(negedge clk);
  endtask

  // Run a job to completion (bounded) with an optional stall window, then check its totals
  task automatic runJob(input string name, input logic [7:0] k, input int stallStart,
                        input int stallLen, input int expLat);
    int n, pops, clears, drains, peStalled;
    bit seenDone;
    n = 0; pops = 0; clears = 0; drains = 0; peStalled = 0; seenDone = 0;
    applyStimulus(1'b1, k, 1'b1);
    while (!seenDone && n < 1000) begin
      logic v;
      n++;
      v = !(n >= stallStart && n < stallStart + stallLen);
      applyStimulus(1'b0, k, v);
      pops   += int'(opndRd);
      clears += int'(regClear);
      drains += int'(ofmapValid);
      if (!v && peEn) peStalled++;
      if (done) seenDone = 1'b1;
    end
    checkVal({name, ".latency"}, n, expLat);
    checkVal({name, ".pops"}, pops, int'(k));
    checkVal({name, ".clears"}, clears, (k == 0) ? 0 : 1);
    checkVal({name, ".drains"}, drains, (k == 0) ? 0 : 2);
    checkVal({name, ".peOnStall"}, peStalled, 0);
  endtask

  initial begin
    int pops, doneCount, doneAt;
    nrst = 1'b0; start = 1'b0; kLen = 8'd0; opndValid = 1'b0;

    // Reset values must appear without any clock edge
    #2;
    checkOutput("resetNoClock", O_IDLE);
    @(posedge clk);
    #1 nrst = 1'b1;

    // K=0 goes straight to DONE; valid in IDLE must not pop
    addVec(1, 0, 1, O_IDLE,  "k0.start");
    addVec(0, 0, 1, O_DONE,  "k0.done");
    addVec(0, 0, 0, O_IDLE,  "k0.idle");
    // K=4 with a 3-cycle stall; k_len change after start has no effect
    addVec(1, 4, 1, O_IDLE,  "st.start");
    addVec(0, 9, 1, O_CLEAR, "st.clear");
    addVec(0, 9, 1, O_FEEDV, "st.beat0");
    addVec(0, 9, 1, O_FEEDV, "st.beat1");
    addVec(0, 9, 0, O_FEEDS, "st.stall0");
    addVec(0, 9, 0, O_FEEDS, "st.stall1");
    addVec(0, 9, 0, O_FEEDS, "st.stall2");
    addVec(0, 9, 1, O_FEEDV, "st.beat2");
    addVec(0, 9, 1, O_FEEDV, "st.beat3");
    addVec(0, 9, 1, O_FLUSH, "st.flush0");
    addVec(0, 9, 1, O_FLUSH, "st.flush1");
    addVec(0, 9, 0, O_DR0,   "st.drain0");
    addVec(0, 9, 0, O_DR1,   "st.drain1");
    addVec(0, 9, 0, O_DONE,  "st.done");
    addVec(0, 9, 0, O_IDLE,  "st.idle");
    // K=4 without stalls; start during DONE is dropped
    addVec(1, 4, 1, O_IDLE,  "ns.start");
    addVec(0, 4, 1, O_CLEAR, "ns.clear");
    addVec(0, 4, 1, O_FEEDV, "ns.beat0");
    addVec(0, 4, 1, O_FEEDV, "ns.beat1");
    addVec(0, 4, 1, O_FEEDV, "ns.beat2");
    addVec(0, 4, 1, O_FEEDV, "ns.beat3");
    addVec(0, 4, 1, O_FLUSH, "ns.flush0");
    addVec(0, 4, 1, O_FLUSH, "ns.flush1");
    addVec(0, 4, 0, O_DR0,   "ns.drain0");
    addVec(0, 4, 0, O_DR1,   "ns.drain1");
    addVec(1, 4, 1, O_DONE,  "ns.doneStart");
    addVec(0, 4, 1, O_IDLE,  "ns.idle0");
    addVec(0, 4, 1, O_IDLE,  "ns.idle1");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].k, vecs[i].valid);
      checkOutput(vecs[i].name, vecs[i].expOut);
    end
`ifdef SA_CTRL_PERF_EN
    checkVal("perf.k4.cycles", longint'(perfCycles), 10);
    checkVal("perf.k4.stalls", longint'(perfStalls), 0);
`endif

    // K=255 with start pulses during FEED and DONE: one job, one done
    pops = 0; doneCount = 0; doneAt = 0;
    applyStimulus(1'b1, 8'd255, 1'b1);
    for (int n = 1; n <= 270; n++) begin
      applyStimulus((n == 50 || n == 261) ? 1'b1 : 1'b0, (n == 10) ? 8'd3 : 8'd255, 1'b1);
      pops += int'(opndRd);
      if (done) begin
        doneCount++;
        if (doneAt == 0) doneAt = n;
      end
    end
    checkVal("k255.pops", pops, 255);
    checkVal("k255.doneCount", doneCount, 1);
    checkVal("k255.doneAt", doneAt, 261);
    checkOutput("k255.idleAfter", O_IDLE);

    // Async reset in DRAIN, then a K=1 job must run cleanly
    applyStimulus(1'b1, 8'd1, 1'b1);
    for (int n = 1; n <= 5; n++) applyStimulus(1'b0, 8'd1, 1'b1);
    checkOutput("rst.inDrain", O_DR0);
    #2 nrst = 1'b0;
    #1;
    checkOutput("rst.async", O_IDLE);
    @(posedge clk);
    #1 nrst = 1'b1;
    runJob("k1", 8'd1, 0, 0, 7);

    // Stalled K=4 job via the generic runner
    runJob("k4stall", 8'd4, 4, 3, 13);
`ifdef SA_CTRL_PERF_EN
    @(negedge clk);
    checkVal("perf.stall.cycles", longint'(perfCycles), 13);
    checkVal("perf.stall.stalls", longint'(perfStalls), 3);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
